// File: rtl/capture_phase_ctrl.sv
// Sampling-phase controller for the oversampled antenna capture path: histograms edge
// positions per channel over CYCLES signal periods and writes the phase opposite the dominant edge.
module capture_phase_ctrl #(
  parameter int WIDTH  = 24,
  parameter int RATIO  = 12,
  parameter int RBITS  = 4,
  parameter int HBITS  = 8,
  parameter int CYCLES = 256,
  parameter int IBITS  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  input  logic [WIDTH-1:0]  d,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic              sel_wr,
  output logic [IBITS-1:0]  sel_idx,
  output logic [RBITS-1:0]  sel_phase
);

  localparam int               CNT_W     = (CYCLES * RATIO > 1) ? $clog2(CYCLES * RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CYCLES * RATIO - 1);
  localparam logic [RBITS-1:0] RLAST     = RBITS'(RATIO - 1);
  localparam logic [IBITS-1:0] LAST_CHAN = IBITS'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ALIGN, S_COUNT, S_SEARCH, S_WRITE, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [RBITS-1:0]   ratio;
  logic [IBITS-1:0]   chan;
  logic               fail;
  logic [CNT_W-1:0]   cnt;
  logic [RBITS-1:0]   sidx;
  logic [HBITS-1:0]   hist [RATIO];
  logic [HBITS-1:0]   max_val;
  logic [RBITS-1:0]   max_idx;
  logic [WIDTH-1:0]   d_p0;
  logic               cur_p0, prev_p1;
  logic               better;
  logic [HBITS-1:0]   fin_val;
  logic [RBITS-1:0]   fin_idx;

  function automatic logic [HBITS-1:0] sat_inc(input logic [HBITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [RBITS-1:0] opposite_phase(input logic [RBITS-1:0] idx);
    int p;
    p = int'(idx) + RATIO / 2;
    if (p >= RATIO) p = p - RATIO;
    return RBITS'(p);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || !ce)        ratio <= '0;
    else if (ratio == RLAST) ratio <= '0;
    else                   ratio <= ratio + 1'b1;
  end

  // Stage p0: registered raw inputs; p1: previous sample of the selected channel
  assign cur_p0 = d_p0[chan];

  // The running maximum folded with the bin under inspection, so the final
  // SEARCH cycle already yields the winner when the write strobe is registered.
  always_comb begin
    better  = hist[sidx] > max_val;
    fin_val = better ? hist[sidx] : max_val;
    fin_idx = better ? sidx : max_idx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start && ce) state_nx = S_CLEAR;
      S_CLEAR:  state_nx = S_ALIGN;
      S_ALIGN:  if (ratio == RLAST) state_nx = S_COUNT;
      S_COUNT:  if (cnt == LAST_CNT) state_nx = S_SEARCH;
      S_SEARCH: if (sidx == RLAST) state_nx = S_WRITE;
      S_WRITE:  state_nx = (chan == LAST_CHAN) ? S_DONE : S_CLEAR;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (state != S_IDLE && !ce) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      chan      <= '0;
      fail      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      locked    <= 1'b0;
      sel_wr    <= 1'b0;
      sel_idx   <= '0;
      sel_phase <= '0;
    end else begin
      state  <= state_nx;
      busy   <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      done   <= (state_nx == S_DONE);
      sel_wr <= (state_nx == S_WRITE);
      if (state == S_IDLE && state_nx == S_CLEAR) begin
        chan <= '0;
        fail <= 1'b0;
      end
      if (state == S_WRITE && state_nx == S_CLEAR) chan <= chan + 1'b1;
      if (state_nx == S_WRITE) begin
        sel_idx   <= chan;
        sel_phase <= (fin_val == '0) ? '0 : opposite_phase(fin_idx);
        if (fin_val == '0) fail <= 1'b1;
      end
      if (state_nx == S_DONE) locked <= !fail;
      if (state == S_DONE) fail <= 1'b0;
      if (state != S_IDLE && !ce) locked <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    d_p0    <= d;
    prev_p1 <= cur_p0;
    case (state)
      S_CLEAR: for (int i = 0; i < RATIO; i++) hist[i] <= '0;
      S_COUNT: if (cur_p0 != prev_p1) hist[ratio] <= sat_inc(hist[ratio]);
      default: ;
    endcase
    if (state == S_ALIGN)      cnt <= '0;
    else if (state == S_COUNT) cnt <= cnt + 1'b1;
    if (state == S_COUNT) begin
      sidx    <= '0;
      max_val <= '0;
      max_idx <= '0;
    end else if (state == S_SEARCH) begin
      sidx    <= sidx + 1'b1;
      max_val <= fin_val;
      max_idx <= fin_idx;
    end
  end

endmodule

// File: tb/tb_capture_phase_ctrl.sv
// Randomised and directed bench for capture_phase_ctrl; edge stimulus is described as
// per-channel, per-bin edge counts per accumulation window and checked against an arithmetic model.
module tb_capture_phase_ctrl;
  localparam int WIDTH = 4, RATIO = 12, RBITS = 4, HBITS = 4, CYCLES = 16, IBITS = 2;
  localparam int HMAX = (1 << HBITS) - 1;
  localparam int CHAN_MAX = CYCLES * RATIO + 2 * RATIO + 3;
  localparam int SCAN_MAX = WIDTH * CHAN_MAX + 40;

  logic clk = 1'b0, rst = 1'b1, ce = 1'b1, start = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic busy, done, locked, sel_wr;
  logic [IBITS-1:0] sel_idx;
  logic [RBITS-1:0] sel_phase;

  capture_phase_ctrl #(.WIDTH(WIDTH), .RATIO(RATIO), .RBITS(RBITS), .HBITS(HBITS),
                       .CYCLES(CYCLES), .IBITS(IBITS)) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .d(d),
    .busy(busy), .done(done), .locked(locked), .sel_wr(sel_wr),
    .sel_idx(sel_idx), .sel_phase(sel_phase));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int kt [WIDTH][RATIO];
  int exp_phase [WIDTH];
  bit exp_ok [WIDTH];
  logic [WIDTH-1:0] lvl = '0;
  int mratio = 0, pcount = 0, cyc = 0;
  bit armed = 1'b0;
  bit active = 1'b0, prev_wr_last = 1'b0, scan_ok = 1'b0, mlocked = 1'b0, edone, ewr;
  int wr_n = 0, exp_wr_cyc = 0, last_idx = 0, last_phase = 0, dut_wr = 0, dut_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Phase opposite the strongest bin (lowest index on ties); -1 when no edges at all.
  function automatic int model_phase(input int ch);
    int bv, bi, h;
    bv = 0; bi = 0;
    for (int s = 0; s < RATIO; s++) begin
      h = (kt[ch][s] > HMAX) ? HMAX : kt[ch][s];
      if (h > bv) begin bv = h; bi = s; end
    end
    return (bv == 0) ? -1 : (bi + RATIO / 2) % RATIO;
  endfunction

  // Accumulation starts at the first period boundary at least 3 cycles after cycle t.
  function automatic int next_wr_cyc(input int t, input int r_t);
    int c;
    c = t + 3;
    while (((r_t + (c - t)) % RATIO) != 0) c++;
    return c + CYCLES * RATIO + RATIO;
  endfunction

  task automatic setup_expect();
    int p;
    for (int ch = 0; ch < WIDTH; ch++) begin
      p = model_phase(ch);
      exp_ok[ch]    = (p >= 0);
      exp_phase[ch] = (p < 0) ? 0 : p;
    end
  endtask

  task automatic clear_k();
    for (int ch = 0; ch < WIDTH; ch++)
      for (int s = 0; s < RATIO; s++) kt[ch][s] = 0;
  endtask

  // Presents the next d so that cur toggles in bin s during period j whenever j mod CYCLES < kt.
  task automatic step();
    int s, j;
    @(posedge clk);
    #1;
    s = (mratio + 1) % RATIO;
    j = pcount + ((s == 0) ? 1 : 0);
    for (int ch = 0; ch < WIDTH; ch++)
      if ((j % CYCLES) < kt[ch][s]) lvl[ch] = ~lvl[ch];
    d = lvl;
  endtask

  task automatic run_scan(input string name, input bit poke);
    int w0, d0, n;
    w0 = dut_wr; d0 = dut_done; n = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (dut_done == d0 && n < SCAN_MAX) begin
      step();
      n++;
      start = (poke && n == 100) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    chk({name, "_timeout"}, n < SCAN_MAX, 1);
    chk({name, "_strobes"}, dut_wr - w0, WIDTH);
    chk({name, "_done"}, dut_done - d0, 1);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) armed <= 1'b1;
    if (rst || !ce) mratio <= 0;
    else if (mratio == RATIO - 1) begin mratio <= 0; pcount <= pcount + 1; end
    else mratio <= mratio + 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      edone = prev_wr_last;
      ewr   = active && !edone && (cyc == exp_wr_cyc);
      if (edone) mlocked = scan_ok;
      if (sel_wr === 1'b1) dut_wr++;
      if (done === 1'b1) dut_done++;
      chk("done", done, edone);
      chk("busy", busy, active && !edone);
      chk("sel_wr", sel_wr, ewr);
      if (ewr) begin last_idx = wr_n; last_phase = exp_phase[wr_n]; end
      chk("sel_idx", sel_idx, last_idx);
      chk("sel_phase", sel_phase, last_phase);
      chk("locked", locked, mlocked);
      prev_wr_last = 1'b0;
      if (rst) begin
        active = 1'b0; mlocked = 1'b0; last_idx = 0; last_phase = 0;
      end else if (active && !ce) begin
        active = 1'b0; mlocked = 1'b0;
      end else if (edone) begin
        active = 1'b0;
      end else if (!active && start && ce) begin
        active = 1'b1; wr_n = 0; scan_ok = 1'b1;
        exp_wr_cyc = next_wr_cyc(cyc, mratio);
      end else if (ewr) begin
        scan_ok = scan_ok && exp_ok[wr_n];
        if (wr_n == WIDTH - 1) prev_wr_last = 1'b1;
        else begin wr_n++; exp_wr_cyc = next_wr_cyc(cyc, mratio); end
      end
    end
  end

  initial begin
    int w0, d0;
    clear_k();
    setup_expect();
    rst = 1'b1; start = 1'b1; ce = 1'b1;
    repeat (5) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_locked", locked, 0);
    chk("rst_sel_wr", sel_wr, 0);
    chk("rst_sel_idx", sel_idx, 0);
    chk("rst_sel_phase", sel_phase, 0);
    rst = 1'b0; start = 1'b0;
    repeat (3) step();
    chk("idle_after_rst", busy, 0);

    // Every channel: one edge per period in bin 3.
    clear_k();
    for (int ch = 0; ch < WIDTH; ch++) kt[ch][3] = CYCLES;
    setup_expect();
    chk("model_bin3", exp_phase[0], 9);
    run_scan("bin3", 1'b0);
    chk("locked_bin3", locked, 1);
    chk("last_phase_bin3", sel_phase, 9);
    chk("last_idx_bin3", sel_idx, WIDTH - 1);

    // Channel 2 moved to bin 8: opposite phase wraps to 2.
    kt[2][3] = 0; kt[2][8] = CYCLES;
    setup_expect();
    chk("model_wrap", exp_phase[2], 2);
    run_scan("wrap", 1'b0);
    chk("locked_wrap", locked, 1);

    // Channel 1 silent, channel 3 has equal counts in bins 2 and 5.
    clear_k();
    kt[0][3] = CYCLES; kt[2][3] = CYCLES;
    kt[3][2] = 10; kt[3][5] = 10;
    setup_expect();
    chk("model_silent", exp_ok[1], 0);
    chk("model_tie", exp_phase[3], 8);
    run_scan("silent_tie", 1'b0);
    chk("locked_silent", locked, 0);

    // Abort in the middle of channel 1's accumulation.
    clear_k();
    for (int ch = 0; ch < WIDTH; ch++) kt[ch][ch + 4] = 7;
    setup_expect();
    w0 = dut_wr;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n < CHAN_MAX && dut_wr == w0; n++) step();
    chk("abort_first_strobe", dut_wr - w0, 1);
    repeat (60) step();
    chk("abort_busy_before", busy, 1);
    ce = 1'b0;
    step();
    chk("abort_busy", busy, 0);
    repeat (3) step();
    ce = 1'b1;
    chk("abort_locked", locked, 0);
    w0 = dut_wr; d0 = dut_done;
    repeat (2 * CHAN_MAX) step();
    chk("abort_no_strobe", dut_wr - w0, 0);
    chk("abort_no_done", dut_done - d0, 0);
    run_scan("restart", 1'b0);
    chk("locked_restart", locked, 1);

    // Saturation: 16 edges in bin 1 must stick at 15, and a start while busy is ignored.
    clear_k();
    for (int ch = 0; ch < WIDTH; ch++) kt[ch][1] = CYCLES;
    setup_expect();
    chk("model_sat", exp_phase[0], 7);
    run_scan("sat", 1'b1);
    chk("locked_sat", locked, 1);

    // Randomised edge distributions, including saturation ties and silent channels.
    for (int r = 0; r < 5; r++) begin
      clear_k();
      for (int ch = 0; ch < WIDTH; ch++)
        if ($urandom_range(0, 7) != 0)
          for (int s = 0; s < RATIO; s++)
            if ($urandom_range(0, 2) == 0) kt[ch][s] = $urandom_range(1, CYCLES);
      setup_expect();
      run_scan("random", 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
